// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 definitions for the host transmitter and receive path.
//   - ps2_tx_state_t : host-to-device transmit FSM states
//   - PS2_CMD_*      : common mouse command bytes
//   - PS2_ACK_BYTE   : byte the device answers with after a command
//   - us_to_cycles   : microseconds to system-clock cycles
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        STOP,
        ACK,
        WAIT_REL,
        DONE,
        ERR
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_RESET        = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE       = 8'hF4;
    localparam logic [7:0] PS2_CMD_SET_DEFAULTS = 8'hF6;
    localparam logic [7:0] PS2_ACK_BYTE         = 8'hFA;

    function automatic int unsigned us_to_cycles(input int unsigned freq_hz,
                                                 input int unsigned us);
        return (freq_hz / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-FF synchronizer for an asynchronous PS/2 line plus a
// one-cycle pulse on the synchronized 1->0 transition.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   i_async  in   raw line from the pad
//   o_sync   out  synchronized line level
//   o_fall   out  1-cycle pulse when o_sync goes 1->0
module ps2_sync_edge #(
    // PS/2 lines idle high; resetting to 1 avoids a bogus fall after reset.
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte
// (start, 8 data LSB first, odd parity, stop) and checks the device ACK.
// Only drives open-drain pull-down enables; lines are released otherwise.
// Ports:
//   clk, rst                 system clock, async active-high reset
//   tx_data/tx_valid/tx_ready byte request, accepted when valid && ready
//   ps2_clk_i/ps2_data_i     raw PS/2 line levels (asynchronous)
//   ps2_clk_oe/ps2_data_oe   1 = pull the line low
//   done / error             1-cycle completion / failure pulses
//   busy                     high whenever not IDLE
// Build option: define PS2_TX_TIMEOUT_EN to add a whole-transfer watchdog
// (TIMEOUT_US) that forces ERR and releases both lines on expiry.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned INHIBIT_US  = 100,
    parameter int unsigned TIMEOUT_US  = 15_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       error,
    output logic       busy
);

    localparam int unsigned INHIBIT_CYCLES = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
    localparam int          ICW            = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [ICW-1:0] INH_LAST    = ICW'(INHIBIT_CYCLES - 1);

    ps2_tx_state_t  r_state, w_nxt;
    logic [8:0]     r_shreg;
    logic [3:0]     r_bitcnt;
    logic [ICW-1:0] r_inh_cnt;
    logic           r_clk_oe, r_data_oe;
    logic           w_clk_oe_nxt, w_data_oe_nxt;
    logic           w_accept, w_shift;
    logic           w_clk_sync, w_clk_fall;
    logic           w_data_sync, w_data_fall_unused;
    logic           w_wd_expired;

    ps2_sync_edge u_clk_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (ps2_clk_i),
        .o_sync  (w_clk_sync),
        .o_fall  (w_clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (ps2_data_i),
        .o_sync  (w_data_sync),
        .o_fall  (w_data_fall_unused)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned TIMEOUT_CYCLES = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
    localparam int          WCW            = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCW-1:0] WD_LAST     = WCW'(TIMEOUT_CYCLES - 1);

    logic [WCW-1:0] r_wd;

    // Counts from the first INHIBIT cycle; held at the limit until IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 r_wd <= '0;
        else if (r_state == IDLE) r_wd <= '0;
        else if (!w_wd_expired)  r_wd <= r_wd + 1'b1;
    end

    assign w_wd_expired = (r_wd == WD_LAST);
`else
    // Watchdog compiled out: TIMEOUT_US is kept only for a uniform interface.
    localparam int unsigned timeout_cfg_unused = TIMEOUT_US;
    assign w_wd_expired = 1'b0;
`endif

    // State register plus registered line enables (glitch-free pad drive).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_data_oe <= w_data_oe_nxt;
        end
    end

    // Next state; the *_oe_nxt values are what the lines do in w_nxt.
    always_comb begin
        w_nxt         = r_state;
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = r_data_oe;
        w_accept      = 1'b0;
        w_shift       = 1'b0;
        case (r_state)
            IDLE: begin
                w_data_oe_nxt = 1'b0;
                if (tx_valid) begin
                    w_accept     = 1'b1;
                    w_nxt        = INHIBIT;
                    w_clk_oe_nxt = 1'b1;
                end
            end
            INHIBIT: begin
                w_clk_oe_nxt = 1'b1;
                if (r_inh_cnt == INH_LAST) begin
                    w_nxt         = REQ;
                    w_data_oe_nxt = 1'b1;  // start bit
                end
            end
            REQ: w_nxt = SHIFT;            // releases clock, keeps start bit
            SHIFT: begin
                if (w_clk_fall) begin
                    w_shift       = 1'b1;
                    w_data_oe_nxt = ~r_shreg[0];
                    if (r_bitcnt == 4'd8) w_nxt = STOP;  // parity just presented
                end
            end
            STOP: begin
                if (w_clk_fall) begin
                    w_data_oe_nxt = 1'b0;  // stop bit = released line
                    w_nxt         = ACK;
                end
            end
            ACK: begin
                if (w_clk_fall) w_nxt = w_data_sync ? ERR : WAIT_REL;
            end
            WAIT_REL: begin
                if (w_clk_sync && w_data_sync) w_nxt = DONE;
            end
            DONE, ERR: begin
                w_data_oe_nxt = 1'b0;
                w_nxt         = IDLE;
            end
            default: begin
                w_data_oe_nxt = 1'b0;
                w_nxt         = IDLE;
            end
        endcase
        if (w_wd_expired && r_state != IDLE && r_state != DONE && r_state != ERR) begin
            w_nxt         = ERR;
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
        end
    end

    // Frame datapath: {parity, data} shifted out LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
        end else if (w_accept) begin
            r_shreg  <= {~^tx_data, tx_data};
            r_bitcnt <= '0;
        end else if (w_shift) begin
            r_shreg  <= {1'b0, r_shreg[8:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_inh_cnt <= '0;
        else if (r_state == INHIBIT) r_inh_cnt <= r_inh_cnt + 1'b1;
        else                         r_inh_cnt <= '0;
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign tx_ready    = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign error       = (r_state == ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int H = 20;  // device clock half period in system cycles

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, done, error, busy;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_i, ps2_data_i;

    // Open-drain wired-AND of host and device pull-downs.
    assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_i = dev_data & ~ps2_data_oe;

    int n_chk = 0, n_fail = 0;
    int n_done = 0, n_err = 0, n_both = 0;

    ps2_host_tx dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .done        (done),
        .error       (error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)          n_done++;
        if (error)         n_err++;
        if (done && error) n_both++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] b, input string name);
        @(posedge clk); #1;
        tx_data = b; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        n_chk++;
        if ({tx_ready, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s accept_ready_busy: got %b expected 01", name, {tx_ready, busy});
        end
    endtask

    // Measures the inhibit phase, then checks REQ and entry to SHIFT.
    task automatic check_inhibit(input string name);
        int cnt;
        cnt = 0;
        while (ps2_clk_oe && !ps2_data_oe && cnt < 20000) begin
            cnt++;
            tick(1);
        end
        n_chk++;
        if (cnt !== 10000) begin
            n_fail++;
            $display("FAIL %s inhibit_len: got %0d expected 10000", name, cnt);
        end
        n_chk++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b11) begin
            n_fail++;
            $display("FAIL %s req_oe: got %b expected 11", name, {ps2_clk_oe, ps2_data_oe});
        end
        tick(1);
        n_chk++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s shift_oe: got %b expected 01", name, {ps2_clk_oe, ps2_data_oe});
        end
        tick(5);
    endtask

    // Full transfer with a device model; inject_at>0 pulses tx_valid=0xAA
    // after that fall/rise pair.
    task automatic run_transfer(input logic [7:0] b, input logic [9:0] exp_bits,
                                input bit ack, input int inject_at, input string name);
        int         d0, e0, w;
        logic [9:0] cap;
        d0 = n_done; e0 = n_err; cap = '0;
        accept(b, name);
        check_inhibit(name);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) begin dev_data = 1'b0; tick(5); end
            dev_clk = 1'b0; tick(H);
            if (k <= 10) cap[k-1] = ps2_data_i;  // value on the rising edge
            dev_clk = 1'b1; tick(H);
            if (k == inject_at) begin
                tx_data = 8'hAA; tx_valid = 1'b1;
                tick(1);
                tx_valid = 1'b0;
                n_chk++;
                if (tx_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s ready_in_shift: got %b expected 0", name, tx_ready);
                end
            end
        end
        dev_data = 1'b1;
        w = 0;
        while (!tx_ready && w < 100) begin w++; tick(1); end
        tick(2);
        n_chk++;
        if (cap !== exp_bits) begin
            n_fail++;
            $display("FAIL %s frame_bits: got %h expected %h", name, cap, exp_bits);
        end
        n_chk++;
        if ((n_done - d0) !== (ack ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s done_pulses: got %0d expected %0d", name, n_done - d0, ack ? 1 : 0);
        end
        n_chk++;
        if ((n_err - e0) !== (ack ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s error_pulses: got %0d expected %0d", name, n_err - e0, ack ? 0 : 1);
        end
        n_chk++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s end_state: got %b expected 1000", name,
                     {tx_ready, busy, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        #2;
        n_chk++;
        if ({tx_ready, ps2_clk_oe, ps2_data_oe, done, error, busy} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 100000",
                     {tx_ready, ps2_clk_oe, ps2_data_oe, done, error, busy});
        end
        tick(3);
        rst = 1'b0;
        tick(3);
        n_chk++;
        if ({tx_ready, ps2_clk_oe, ps2_data_oe, done, error, busy} !== 6'b100000) begin
            n_fail++;
            $display("FAIL post_reset_outputs: got %b expected 100000",
                     {tx_ready, ps2_clk_oe, ps2_data_oe, done, error, busy});
        end
    endtask

    task automatic test_reset_mid_transfer;
        accept(8'hF4, "rst_mid");
        check_inhibit("rst_mid");
        for (int k = 1; k <= 4; k++) begin
            dev_clk = 1'b0; tick(H);
            if (k < 4) begin dev_clk = 1'b1; tick(H); end
        end
        // After fall 4 the host presents bit3 of 0xF4 = 0, i.e. pulls data low.
        n_chk++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_mid pre_reset_oe: got %b expected 01", {ps2_clk_oe, ps2_data_oe});
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_mid async_release: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
        end
        dev_clk = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(3);
        n_chk++;
        if ({tx_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_mid ready_after: got %b expected 10", {tx_ready, busy});
        end
    endtask

    task automatic test_no_timeout;
        int e0;
        e0 = n_err;
        accept(8'h55, "silent");
        tick(12000);
        n_chk++;
        if ({busy, ps2_clk_oe, ps2_data_oe} !== 3'b101) begin
            n_fail++;
            $display("FAIL silent stuck_in_shift: got %b expected 101", {busy, ps2_clk_oe, ps2_data_oe});
        end
        n_chk++;
        if ((n_err - e0) !== 0) begin
            n_fail++;
            $display("FAIL silent error_pulses: got %0d expected 0", n_err - e0);
        end
        rst = 1'b1; tick(2); rst = 1'b0; tick(3);
        n_chk++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL silent ready_after_rst: got %b expected 1", tx_ready);
        end
    endtask

    initial begin
        test_reset();
        // Frame captured as {stop, parity, data[7:0]}.
        run_transfer(8'hF4, 10'h2F4, 1'b1, 0, "send_F4");
        run_transfer(8'hFF, 10'h3FF, 1'b1, 0, "send_FF");
        run_transfer(8'h00, 10'h300, 1'b1, 0, "send_00");
        run_transfer(8'hF4, 10'h2F4, 1'b0, 0, "no_ack");
        test_reset_mid_transfer();
        run_transfer(8'hF4, 10'h2F4, 1'b1, 4, "ignore_valid");
        test_no_timeout();
        n_chk++;
        if (n_both !== 0) begin
            n_fail++;
            $display("FAIL done_error_overlap: got %0d expected 0", n_both);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
